// File: rtl/tick_scheduler_pkg.sv
// Shared types and default sizing for the tick scheduler.
package tick_sched_pkg;

  localparam int unsigned CNT_W_DEF       = 32;
  localparam int unsigned STEP_W_DEF      = 16;
  localparam int unsigned TCNT_W_DEF      = 32;
  localparam int unsigned DEFAULT_DIV_DEF = 2500000;  // 20 Hz at 50 MHz

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_PERIOD = 2'd1,
    WAIT_DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/tick_scheduler_period_counter.sv
// Saturating period counter. term means the current cycle is the last one
// of a period of length limit (limit is expected to be at least 1).
module period_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk_in,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         term
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins over enable; the count sticks at all-ones.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  // A zero limit is never loaded, but treat it like 1 rather than wrapping.
  assign term  = (limit == '0) || (count_q >= (limit - W'(1)));

endmodule

// File: rtl/tick_scheduler.sv
// Tick scheduler: issues one-cycle tick strobes at a programmable period,
// waits for the core's tick_done between ticks, supports free-run (run)
// and N-step (step_req/step_count) operation and flags period overruns.
//
// Handshake: tick is a one-cycle request strobe; the core answers with
// tick_done held for at least one cycle, which may coincide with the tick
// cycle itself. No new tick is issued until tick_done has been seen.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned STEP_W      = STEP_W_DEF,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF,
  parameter int unsigned TCNT_W      = TCNT_W_DEF
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic [CNT_W-1:0]  div_value,
  input  logic              div_load,
  input  logic              run,
  input  logic              step_req,
  input  logic [STEP_W-1:0] step_count,
  output logic              tick,
  input  logic              tick_done,
  output logic              busy,
  output logic              overrun,
  output logic [TCNT_W-1:0] tick_count,
  output state_e            state_dbg,
  output logic [CNT_W-1:0]  count_dbg
);

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   steps_left_q, steps_left_d;
  logic [TCNT_W-1:0]   tick_count_q, tick_count_d;
  logic [CNT_W-1:0]    div_reg_q, div_reg_d;
  logic                overrun_q, overrun_d;
  logic                tick_q, tick_d;
  logic                busy_q, busy_d;

  logic                cnt_clear;
  logic                cnt_enable;
  logic                cnt_term;
  logic [CNT_W-1:0]    cnt_count;

  period_counter #(.W(CNT_W)) u_period_counter (
    .clk_in (clk_in),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .limit  (div_reg_q),
    .count  (cnt_count),
    .term   (cnt_term)
  );

  // Next-state, counter control and bookkeeping for the tick FSM.
  always_comb begin
    state_d      = state_q;
    steps_left_d = steps_left_q;
    tick_count_d = tick_count_q;
    div_reg_d    = div_reg_q;
    overrun_d    = overrun_q;
    tick_d       = 1'b0;
    cnt_clear    = 1'b0;
    cnt_enable   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_clear = 1'b1;
        if (run) begin
          state_d = WAIT_PERIOD;
        end else if (step_req && (step_count != '0)) begin
          steps_left_d = step_count;
          state_d      = WAIT_PERIOD;
        end
      end

      WAIT_PERIOD: begin
        cnt_enable = 1'b1;
        if (!run && (steps_left_q == '0)) begin
          cnt_clear = 1'b1;
          state_d   = IDLE;
        end else if (cnt_term) begin
          tick_d    = 1'b1;
          cnt_clear = 1'b1;
          state_d   = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        // The counter keeps running so the period is measured tick-to-tick.
        cnt_enable = 1'b1;
        if (tick_done) begin
          tick_count_d = tick_count_q + TCNT_W'(1);
          if (!run && (steps_left_q != '0)) begin
            steps_left_d = steps_left_q - STEP_W'(1);
          end
          if (!run && (steps_left_d == '0)) begin
            cnt_clear = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d = WAIT_PERIOD;
          end
        end else if (cnt_term) begin
          overrun_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A new period also starts a fresh overrun observation window.
    if (div_load) begin
      div_reg_d = (div_value == '0) ? CNT_W'(1) : div_value;
      overrun_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q      <= IDLE;
      steps_left_q <= '0;
      tick_count_q <= '0;
      div_reg_q    <= CNT_W'(DEFAULT_DIV);
      overrun_q    <= 1'b0;
      tick_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      steps_left_q <= steps_left_d;
      tick_count_q <= tick_count_d;
      div_reg_q    <= div_reg_d;
      overrun_q    <= overrun_d;
      tick_q       <= tick_d;
      busy_q       <= busy_d;
    end
  end

  assign tick       = tick_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;
  assign tick_count = tick_count_q;
  assign state_dbg  = state_q;
  assign count_dbg  = cnt_count;

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler. Inputs change 1 ns after the rising
// edge, outputs are sampled at the same point. The reset period is
// overridden to 7 so that the reset value of the divider is observable.
module tb_tick_scheduler;
  import tick_sched_pkg::*;

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned STEP_W = 16;
  localparam int unsigned TCNT_W = 32;
  localparam int unsigned TB_DEFAULT_DIV = 7;

  logic              clk_in = 1'b0;
  logic              reset = 1'b1;
  logic [CNT_W-1:0]  div_value = '0;
  logic              div_load = 1'b0;
  logic              run = 1'b0;
  logic              step_req = 1'b0;
  logic [STEP_W-1:0] step_count = '0;
  logic              tick;
  logic              tick_done = 1'b0;
  logic              busy;
  logic              overrun;
  logic [TCNT_W-1:0] tick_count;
  state_e            state_dbg;
  logic [CNT_W-1:0]  count_dbg;

  int n_vec = 0;
  int n_err = 0;
  int cyc_n = 0;

  // Observation record for the current scenario.
  int tick_cyc_q[$];
  int last_done_c;
  int busy_drop_c;
  int seen_busy;
  int done_in;
  int done_delay;

  tick_scheduler #(
    .CNT_W(CNT_W), .STEP_W(STEP_W), .DEFAULT_DIV(TB_DEFAULT_DIV), .TCNT_W(TCNT_W)
  ) dut (
    .clk_in(clk_in), .reset(reset), .div_value(div_value), .div_load(div_load),
    .run(run), .step_req(step_req), .step_count(step_count), .tick(tick),
    .tick_done(tick_done), .busy(busy), .overrun(overrun), .tick_count(tick_count),
    .state_dbg(state_dbg), .count_dbg(count_dbg)
  );

  // Clock and watchdog.
  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk_in);
    #1;
    cyc_n++;
  endtask

  task automatic clear_rec();
    tick_cyc_q.delete();
    last_done_c = -1;
    busy_drop_c = -1;
    seen_busy   = 0;
    done_in     = 0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; run = 1'b0; step_req = 1'b0; div_load = 1'b0;
    tick_done = 1'b0; step_count = '0; div_value = '0;
    repeat (n) cyc();
    reset = 1'b0;
    clear_rec();
  endtask

  task automatic load_div(input logic [CNT_W-1:0] v);
    div_value = v;
    div_load  = 1'b1;
    cyc();
    div_load  = 1'b0;
  endtask

  // Core model: answers each tick with a one-cycle tick_done done_delay
  // cycles later (0 = in the tick cycle itself) and logs what it sees.
  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      cyc();
      tick_done = 1'b0;
      if (done_in > 0) begin
        done_in--;
        if (done_in == 0) begin
          tick_done   = 1'b1;
          last_done_c = cyc_n;
        end
      end
      if (tick === 1'b1) begin
        tick_cyc_q.push_back(cyc_n);
        if (done_delay == 0) begin
          tick_done   = 1'b1;
          last_done_c = cyc_n;
        end else begin
          done_in = done_delay;
        end
      end
      if (busy === 1'b1) seen_busy = 1;
      if ((busy === 1'b0) && (seen_busy != 0) && (busy_drop_c < 0)) busy_drop_c = cyc_n;
    end
  endtask

  function automatic int first_tick(input int base);
    if (tick_cyc_q.size() == 0) return -1;
    return tick_cyc_q[0] - base;
  endfunction

  function automatic int bad_gaps(input int g);
    int bad = 0;
    for (int i = 1; i < tick_cyc_q.size(); i++)
      if (tick_cyc_q[i] - tick_cyc_q[i-1] != g) bad++;
    return bad;
  endfunction

  task automatic test_reset();
    do_reset(3);
    n_vec++; if (tick !== 1'b0) begin n_err++; $display("FAIL reset_tick: got %b expected 0", tick); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    n_vec++; if (tick_count !== '0) begin n_err++; $display("FAIL reset_tick_count: got %0d expected 0", tick_count); end
    n_vec++; if (state_dbg !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, IDLE); end
  endtask

  task automatic test_free_run();
    int base;
    do_reset(2);
    load_div(10);
    clear_rec();
    done_delay = 0;
    run = 1'b1;
    base = cyc_n;
    run_cycles(55);
    // Entry edge is sample 1; counter reaches 9 at sample 10, strobe at 11.
    n_vec++; if (tick_cyc_q.size() != 5) begin n_err++; $display("FAIL free_run_ticks: got %0d expected 5", tick_cyc_q.size()); end
    n_vec++; if (first_tick(base) != 11) begin n_err++; $display("FAIL free_run_first: got %0d expected 11", first_tick(base)); end
    n_vec++; if (bad_gaps(10) != 0) begin n_err++; $display("FAIL free_run_period: got %0d bad gaps expected 0", bad_gaps(10)); end
    n_vec++; if (tick_count !== 32'd5) begin n_err++; $display("FAIL free_run_count: got %0d expected 5", tick_count); end
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL free_run_overrun: got %b expected 0", overrun); end
    run = 1'b0;
    run_cycles(3);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL free_run_stop_busy: got %b expected 0", busy); end
  endtask

  task automatic test_step();
    int base;
    do_reset(2);
    load_div(4);
    // A zero-length step request does nothing.
    step_count = '0;
    step_req = 1'b1;
    cyc();
    step_req = 1'b0;
    cyc();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL step_zero_busy: got %b expected 0", busy); end
    clear_rec();
    done_delay = 1;
    step_count = 16'd3;
    step_req = 1'b1;
    base = cyc_n;
    run_cycles(1);
    step_req = 1'b0;
    run_cycles(24);
    n_vec++; if (tick_cyc_q.size() != 3) begin n_err++; $display("FAIL step_ticks: got %0d expected 3", tick_cyc_q.size()); end
    n_vec++; if (first_tick(base) != 5) begin n_err++; $display("FAIL step_first: got %0d expected 5", first_tick(base)); end
    n_vec++; if (bad_gaps(4) != 0) begin n_err++; $display("FAIL step_period: got %0d bad gaps expected 0", bad_gaps(4)); end
    n_vec++; if (last_done_c - base != 14) begin n_err++; $display("FAIL step_last_done: got %0d expected 14", last_done_c - base); end
    n_vec++; if (busy_drop_c != last_done_c + 1) begin n_err++; $display("FAIL step_busy_drop: got %0d expected %0d", busy_drop_c, last_done_c + 1); end
    n_vec++; if (tick_count !== 32'd3) begin n_err++; $display("FAIL step_count: got %0d expected 3", tick_count); end
  endtask

  task automatic test_overrun();
    int base;
    do_reset(2);
    load_div(5);
    clear_rec();
    done_delay = 8;
    run = 1'b1;
    base = cyc_n;
    run_cycles(40);
    // Ticks at 6,16,26,36: done lands 8 cycles after each tick, the fire
    // decision is made in the next cycle and the strobe shows one later.
    n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL overrun_set: got %b expected 1", overrun); end
    n_vec++; if (tick_cyc_q.size() != 4) begin n_err++; $display("FAIL overrun_ticks: got %0d expected 4", tick_cyc_q.size()); end
    n_vec++; if (first_tick(base) != 6) begin n_err++; $display("FAIL overrun_first: got %0d expected 6", first_tick(base)); end
    n_vec++; if (bad_gaps(10) != 0) begin n_err++; $display("FAIL overrun_gap: got %0d bad gaps expected 0", bad_gaps(10)); end
    run = 1'b0;
    run_cycles(8);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL overrun_idle: got %b expected 0", busy); end
    n_vec++; if (tick_count !== 32'd4) begin n_err++; $display("FAIL overrun_count: got %0d expected 4", tick_count); end
    n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
    load_div(5);
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL overrun_clear: got %b expected 0", overrun); end
  endtask

  task automatic test_div_zero();
    int base;
    do_reset(2);
    load_div(0);
    clear_rec();
    done_delay = 0;
    run = 1'b1;
    base = cyc_n;
    run_cycles(20);
    n_vec++; if (tick_cyc_q.size() != 10) begin n_err++; $display("FAIL div0_ticks: got %0d expected 10", tick_cyc_q.size()); end
    n_vec++; if (first_tick(base) != 2) begin n_err++; $display("FAIL div0_first: got %0d expected 2", first_tick(base)); end
    n_vec++; if (bad_gaps(2) != 0) begin n_err++; $display("FAIL div0_period: got %0d bad gaps expected 0", bad_gaps(2)); end
    n_vec++; if (tick_count !== 32'd9) begin n_err++; $display("FAIL div0_count: got %0d expected 9", tick_count); end
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL div0_overrun: got %b expected 0", overrun); end
    run = 1'b0;
    run_cycles(4);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL div0_idle: got %b expected 0", busy); end
    n_vec++; if (tick_count !== 32'd10) begin n_err++; $display("FAIL div0_final_count: got %0d expected 10", tick_count); end
  endtask

  task automatic test_run_drop();
    int base;
    do_reset(2);
    load_div(6);
    clear_rec();
    done_delay = 5;
    run = 1'b1;
    base = cyc_n;
    run_cycles(7);
    n_vec++; if (first_tick(base) != 7) begin n_err++; $display("FAIL drop_first: got %0d expected 7", first_tick(base)); end
    run = 1'b0;
    run_cycles(10);
    n_vec++; if (tick_cyc_q.size() != 1) begin n_err++; $display("FAIL drop_ticks: got %0d expected 1", tick_cyc_q.size()); end
    n_vec++; if (last_done_c - base != 12) begin n_err++; $display("FAIL drop_done: got %0d expected 12", last_done_c - base); end
    n_vec++; if (busy_drop_c - base != 13) begin n_err++; $display("FAIL drop_busy: got %0d expected 13", busy_drop_c - base); end
    n_vec++; if (tick_count !== 32'd1) begin n_err++; $display("FAIL drop_count: got %0d expected 1", tick_count); end
  endtask

  task automatic test_reset_mid();
    int base;
    do_reset(2);
    load_div(6);
    clear_rec();
    done_delay = 0;
    run = 1'b1;
    run_cycles(20);
    n_vec++; if (tick_count !== 32'd3) begin n_err++; $display("FAIL mid_pre_count: got %0d expected 3", tick_count); end
    done_delay = 10;
    run_cycles(5);
    n_vec++; if (tick !== 1'b1) begin n_err++; $display("FAIL mid_in_tick: got %b expected 1", tick); end
    reset = 1'b1;
    tick_done = 1'b0;
    cyc();
    reset = 1'b0;
    run = 1'b0;
    clear_rec();
    n_vec++; if (tick !== 1'b0) begin n_err++; $display("FAIL mid_tick: got %b expected 0", tick); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b expected 0", busy); end
    n_vec++; if (tick_count !== '0) begin n_err++; $display("FAIL mid_count: got %0d expected 0", tick_count); end
    n_vec++; if (state_dbg !== IDLE) begin n_err++; $display("FAIL mid_state: got %0d expected %0d", state_dbg, IDLE); end
    // Late answer for the abandoned tick.
    tick_done = 1'b1;
    cyc();
    tick_done = 1'b0;
    cyc();
    n_vec++; if (tick_count !== '0) begin n_err++; $display("FAIL mid_late_done: got %0d expected 0", tick_count); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_late_busy: got %b expected 0", busy); end
    // Divider must be back at its reset value (7).
    done_delay = 0;
    run = 1'b1;
    base = cyc_n;
    run_cycles(30);
    n_vec++; if (first_tick(base) != 8) begin n_err++; $display("FAIL mid_default_first: got %0d expected 8", first_tick(base)); end
    n_vec++; if (tick_cyc_q.size() != 4) begin n_err++; $display("FAIL mid_default_ticks: got %0d expected 4", tick_cyc_q.size()); end
    n_vec++; if (bad_gaps(7) != 0) begin n_err++; $display("FAIL mid_default_period: got %0d bad gaps expected 0", bad_gaps(7)); end
    run = 1'b0;
    run_cycles(3);
  endtask

  initial begin
    clear_rec();
    done_delay = 0;
    test_reset();
    test_free_run();
    test_step();
    test_overrun();
    test_div_zero();
    test_run_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
